miriscv_mem_arbiter: RTL
========================

# miriscv_mem_arbiter

Shares one memory port between the instruction-fetch requester and the load/store requester of the miriscv core. It grants one request per cycle and gives the data side priority, bounded by an anti-starvation counter for fetch. It tracks the owner of every outstanding transaction and routes in-order responses back to that owner. It sits between the core (fetch unit and LSU) and the single-ported memory/bus.

## Interface
- `MAX_DATA_STREAK`, default 4: consecutive data grants allowed while an instruction request is pending; then fetch wins once.
- `OUTSTANDING`, default 2: maximum granted-but-unanswered transactions (≥1).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; **one clock; reset is synchronous and active-high**.
- `instr_req_i` in 1: fetch request.
- `instr_addr_i` in XLEN: fetch address.
- `instr_gnt_o` out 1: fetch request accepted this cycle.
- `instr_rvalid_o` out 1: fetch response valid.
- `instr_rdata_o` out XLEN: fetch response data.
- `data_req_i` in 1: LSU request.
- `data_we_i` in 1: write enable.
- `data_be_i` in XLEN/8: byte enables.
- `data_addr_i` in XLEN: LSU address.
- `data_wdata_i` in XLEN: write data.
- `data_gnt_o` out 1: LSU request accepted this cycle.
- `data_rvalid_o` out 1: LSU response valid (reads and writes).
- `data_rdata_o` out XLEN: LSU read data.
- `mem_req_o`, `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wdata_o` out: memory request channel.
- `mem_gnt_i` in 1: memory accepts request.
- `mem_rvalid_i` in 1: memory response, one per granted transaction, in order.
- `mem_rdata_i` in XLEN: response data.
- `arb_err_o` out 1: sticky flag, set when `mem_rvalid_i` arrives with no outstanding transaction.

## Operation
- Requesters hold req/addr/attributes stable until their grant.
- Selection (combinational) applies only when the tracker is not full:
  - Only one side requests: that side is selected.
  - Both request: data is selected, unless `streak_cnt == MAX_DATA_STREAK`; then instr is selected.
- `mem_req_o` equals the selected request. The selected side's address and attributes are muxed to `mem_*`. For instr: `we=0`, `be='1`, `wdata=0`.
- `<side>_gnt_o = mem_gnt_i & mem_req_o & selected==side`.
- Streak counter, width `$clog2(MAX_DATA_STREAK+1)`:
  - Increments on a data grant while `instr_req_i` is high, saturating.
  - Clears on an instr grant.
  - Clears on any cycle where `instr_req_i` is low.
- Tracker: FIFO of owner IDs, depth `OUTSTANDING`.
  - Push on any grant.
  - Pop on `mem_rvalid_i` when non-empty.
- Response routing: the head owner selects `instr_rvalid_o` or `data_rvalid_o`. Both rdata outputs are driven with `mem_rdata_i`.
- `mem_rvalid_i` with an empty FIFO is dropped and sets `arb_err_o`. Only reset clears `arb_err_o`.
- Full FIFO: `mem_req_o=0`, both grants 0. This holds even if a response arrives in the same cycle, so there is no rvalid→req combinational path.
- Simultaneous push and pop when not full: both happen, and the count is unchanged.
- Fetch kill is not handled here. Responses to killed fetches are still delivered; the fetch unit discards them.

## Timing
- Grant is combinational in the request cycle: zero added latency.
- Response is combinational from `mem_rvalid_i`: zero added latency.
- Throughput: one grant per cycle while not full.
- Reset values:
  - Registered state: FIFO empty, `streak_cnt=0`, `arb_err_o=0`.
  - While `rst_i` is high, all outputs are forced to 0: `mem_req_o`, gnts, rvalids, `mem_*`.
- Reset mid-operation:
  - Outstanding entries are discarded.
  - Late memory responses after reset set `arb_err_o`. The integration must reset the memory together with the arbiter.

## Structure
- In `miriscv_pkg`: `typedef enum logic {ARB_OWNER_INSTR, ARB_OWNER_DATA} arb_owner_e`.
- Sub-module `miriscv_arb_owner_fifo`:
  - Parameterised depth, element `arb_owner_e`.
  - Ports: push, pop, head, full, empty.
  - Pointer wrap-around handles non-power-of-2 depths.
- Top level holds the selection logic, streak counter, muxes, and error flag.

## Test plan
- Reset: `rst_i=1` for 3 cycles with both reqs high → all gnts/rvalids 0, `arb_err_o=0`. After release, the first grant goes to data.
- Single instr read: addr 0x80, `mem_gnt_i=1`, rvalid 1 cycle later with 0x00000013 → `instr_gnt_o=1` in cycle 0; `instr_rvalid_o=1`, rdata 0x13 in cycle 1; `data_rvalid_o=0`.
- Starvation: both reqs held high, `mem_gnt_i=1`, `MAX_DATA_STREAK=4` → grant pattern D,D,D,D,I,D,D,D,D,I.
- Full tracker: `OUTSTANDING=2`, two grants with no rvalid → third cycle `mem_req_o=0`. An rvalid in that cycle does not grant; the next cycle grants.
- Interleaved routing: grants I, D(write), I; responses 0xA, 0xB, 0xC → instr gets 0xA, data gets rvalid (0xB), instr gets 0xC.
- Spurious response: rvalid with empty tracker → no requester rvalid, `arb_err_o` rises and stays 1 until reset.

Source files
------------

// File: rtl/miriscv_pkg.sv
// Shared types for the miriscv memory arbiter: data width and transaction owner IDs.
package miriscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    ARB_OWNER_INSTR,
    ARB_OWNER_DATA
  } arb_owner_e;

endpackage

// File: rtl/miriscv_arb_owner_fifo.sv
// In-order FIFO of owner IDs, one entry per granted but unanswered memory transaction.
module miriscv_arb_owner_fifo
  import miriscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  arb_owner_e push_owner,
  input  logic       pop,
  output arb_owner_e head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  arb_owner_e            mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  do_push, do_pop;

  // Explicit wrap so depths that are not a power of two stay in range.
  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    full    = (count_q == CntW'(DEPTH));
    empty   = (count_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_owner;
  end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares one memory port between fetch and LSU: data-priority arbitration with a fetch
// anti-starvation streak limit, and in-order response routing back to each owner.
module miriscv_mem_arbiter
  import miriscv_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned OUTSTANDING     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_req_i,
  input  logic [XLEN-1:0]   instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [XLEN-1:0]   instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              arb_err_o
);

  localparam int unsigned StreakW = $clog2(MAX_DATA_STREAK + 1);

  logic [StreakW-1:0] streak_q;
  logic               streak_max;
  logic               arb_err_q;
  logic               sel_instr, sel_data;
  logic               fifo_full, fifo_empty;
  logic               rsp_valid;
  arb_owner_e         head_owner, push_owner;

  always_comb begin
    streak_max = (streak_q == StreakW'(MAX_DATA_STREAK));
    // A full tracker blocks all requests, independent of any same-cycle response.
    sel_instr  = !rst_i && !fifo_full && instr_req_i && (!data_req_i || streak_max);
    sel_data   = !rst_i && !fifo_full && data_req_i && !sel_instr;

    mem_req_o   = sel_instr || sel_data;
    instr_gnt_o = mem_gnt_i && sel_instr;
    data_gnt_o  = mem_gnt_i && sel_data;

    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (sel_data) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else if (sel_instr) begin
      mem_be_o    = '1;
      mem_addr_o  = instr_addr_i;
    end

    push_owner     = data_gnt_o ? ARB_OWNER_DATA : ARB_OWNER_INSTR;
    rsp_valid      = !rst_i && mem_rvalid_i && !fifo_empty;
    instr_rvalid_o = rsp_valid && (head_owner == ARB_OWNER_INSTR);
    data_rvalid_o  = rsp_valid && (head_owner == ARB_OWNER_DATA);
    instr_rdata_o  = rst_i ? '0 : mem_rdata_i;
    data_rdata_o   = rst_i ? '0 : mem_rdata_i;
    arb_err_o      = arb_err_q && !rst_i;
  end

  miriscv_arb_owner_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_owner_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (instr_gnt_o || data_gnt_o),
    .push_owner (push_owner),
    .pop        (rsp_valid),
    .head       (head_owner),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      streak_q  <= '0;
      arb_err_q <= 1'b0;
    end else begin
      if (!instr_req_i || instr_gnt_o) begin
        streak_q <= '0;
      end else if (data_gnt_o && !streak_max) begin
        streak_q <= streak_q + 1'b1;
      end
      if (mem_rvalid_i && fifo_empty) arb_err_q <= 1'b1;
    end
  end

endmodule
